multicycle_ctrl_fsm: RTL and testbench

// Multicycle control unit for the stack-based processor datapath. Takes the 32-bit instruction the datapath

---
 rtl/cpu_isa_pkg.sv | 87 ++++++++
 rtl/ctrl_decode.sv | 57 +++++
 rtl/multicycle_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the stack-processor multicycle control unit:
// opcodes, branch codes, FSM state encoding, instruction classes and the control bundle.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] OP_ALUI_LO   = 6'h08;
  localparam logic [5:0] OP_ALUI_HI   = 6'h0F;
  localparam logic [5:0] OP_LD        = 6'h10;
  localparam logic [5:0] OP_ST        = 6'h11;
  localparam logic [5:0] OP_BR        = 6'h12;
  localparam logic [5:0] OP_BZ        = 6'h13;
  localparam logic [5:0] OP_BNZ       = 6'h14;
  localparam logic [5:0] OP_BMI       = 6'h15;
  localparam logic [5:0] OP_MOVE      = 6'h18;
  localparam logic [5:0] OP_PUSH      = 6'h19;
  localparam logic [5:0] OP_POP       = 6'h1A;
  localparam logic [5:0] OP_CALL      = 6'h1B;
  localparam logic [5:0] OP_RET       = 6'h1C;
  localparam logic [5:0] OP_HALT      = 6'h3F;

  localparam logic [1:0] BR_NONE      = 2'b00;
  localparam logic [1:0] BR_ZERO      = 2'b01;
  localparam logic [1:0] BR_NONZERO   = 2'b10;
  localparam logic [1:0] BR_NEG       = 2'b11;

  localparam logic [3:0] ALU_ADD      = 4'h0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Exactly one field is set for any opcode.
  typedef struct packed {
    logic rtype;
    logic alui;
    logic ld;
    logic st;
    logic br;
    logic bcc;
    logic move;
    logic push;
    logic pop;
    logic call;
    logic ret;
    logic halt;
    logic illegal;
  } iclass_t;

  typedef struct packed {
    logic       pc_update;
    logic       reg_dest;
    logic       write_sp;
    logic       read_sp;
    logic       update_sp;
    logic       write_reg;
    logic       alu_source;
    logic       pm4;
    logic       spmmux;
    logic       ret_mem;
    logic       mem_read;
    logic       mem_write;
    logic       mem_reg;
    logic       spmux;
    logic       move_reg;
    logic       jump;
    logic       ret_pc;
    logic       halt_pc;
    logic       retire;
    logic       halted;
    logic [1:0] branch;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic is_stack(iclass_t c);
    return c.push | c.pop | c.call | c.ret;
  endfunction

  function automatic logic needs_mem(iclass_t c);
    return c.ld | c.st | is_stack(c);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the opcode and derives the
// ALU function and branch condition the datapath needs.
module ctrl_decode
  import cpu_isa_pkg::*;
(
  input  logic [31:0] ir_i,
  output iclass_t     cls_o,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  branch_o
);

  logic [5:0] op;
  logic       unused_ir_bits;

  assign op             = ir_i[31:26];
  assign unused_ir_bits = ^ir_i[25:4];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cls_o    = '0;
    alu_op_o = ALU_ADD;
    branch_o = BR_NONE;
    case (op) inside
      OP_RTYPE: begin
        cls_o.rtype = 1'b1;
        alu_op_o    = ir_i[3:0];
      end
      [OP_ALUI_LO:OP_ALUI_HI]: begin
        cls_o.alui = 1'b1;
        alu_op_o   = {1'b0, op[2:0]};
      end
      OP_LD:   cls_o.ld   = 1'b1;
      OP_ST:   cls_o.st   = 1'b1;
      OP_BR:   cls_o.br   = 1'b1;
      OP_BZ: begin
        cls_o.bcc = 1'b1;
        branch_o  = BR_ZERO;
      end
      OP_BNZ: begin
        cls_o.bcc = 1'b1;
        branch_o  = BR_NONZERO;
      end
      OP_BMI: begin
        cls_o.bcc = 1'b1;
        branch_o  = BR_NEG;
      end
      OP_MOVE: cls_o.move = 1'b1;
      OP_PUSH: cls_o.push = 1'b1;
      OP_POP:  cls_o.pop  = 1'b1;
      OP_CALL: cls_o.call = 1'b1;
      OP_RET:  cls_o.ret  = 1'b1;
      OP_HALT: cls_o.halt = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the stack processor: FETCH/DECODE/EXEC/MEM/WB/HALT with
// registered (Moore) datapath controls, retired-instruction counter and sticky illegal flag.
module multicycle_ctrl_fsm
  import cpu_isa_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter bit          STRICT_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  output logic             PCUpdate,
  output logic             regDest,
  output logic             writeSP,
  output logic             readSP,
  output logic             updateSP,
  output logic             writeReg,
  output logic             aluSource,
  output logic             PM4,
  output logic             spmmux,
  output logic             retMem,
  output logic             memRead,
  output logic             memWrite,
  output logic             memReg,
  output logic             spmux,
  output logic             moveReg,
  output logic             jump,
  output logic             retPC,
  output logic             haltPC,
  output logic [1:0]       branch,
  output logic [3:0]       aluOp,
  output logic             retire,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  iclass_t          cls;
  logic [3:0]       alu_op_dec;
  logic [1:0]       branch_dec;
  logic             to_halt;
  logic             unused_cls_bits;

  // Outputs are registered from the next state, so DECODE must already see the instruction being latched.
  assign ir_d            = (state_q == S_FETCH) ? instr : ir_q;
  assign unused_cls_bits = cls.bcc;

  ctrl_decode u_decode (
    .ir_i     (ir_d),
    .cls_o    (cls),
    .alu_op_o (alu_op_dec),
    .branch_o (branch_dec)
  );

  assign to_halt = cls.halt | (STRICT_ILLEGAL & cls.illegal);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = to_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = needs_mem(cls) ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    if (state_d inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ctrl_d.reg_dest   = cls.rtype;
      ctrl_d.alu_source = cls.alui | cls.ld | cls.st;
      ctrl_d.spmux      = is_stack(cls);
      ctrl_d.alu_op     = alu_op_dec;
      ctrl_d.branch     = branch_dec;
    end
    case (state_d)
      S_DECODE: ctrl_d.read_sp = is_stack(cls);
      S_MEM: begin
        ctrl_d.mem_read  = cls.ld | cls.pop | cls.ret;
        ctrl_d.mem_write = cls.st | cls.push | cls.call;
        ctrl_d.ret_mem   = cls.call;
        ctrl_d.update_sp = cls.call;
      end
      S_WB: begin
        ctrl_d.pc_update = 1'b1;
        ctrl_d.retire    = 1'b1;
        ctrl_d.write_reg = cls.rtype | cls.alui | cls.ld | cls.move | cls.pop;
        ctrl_d.mem_reg   = cls.ld | cls.pop;
        ctrl_d.move_reg  = cls.move;
        ctrl_d.write_sp  = is_stack(cls);
        ctrl_d.pm4       = cls.push | cls.call;
        ctrl_d.jump      = cls.br | cls.call;
        ctrl_d.ret_pc    = cls.ret;
      end
      S_HALT: begin
        ctrl_d.halt_pc   = 1'b1;
        ctrl_d.pc_update = 1'b1;
        ctrl_d.halted    = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_d = illegal_q |
                     ((state_q == S_DECODE) && (state_d == S_HALT) && cls.illegal);
  assign icount_d  = ((state_d == S_WB) && (icount_q != {CNT_W{1'b1}})) ?
                     icount_q + CNT_W'(1) : icount_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      icount_q  <= icount_d;
    end
  end

  assign PCUpdate  = ctrl_q.pc_update;
  assign regDest   = ctrl_q.reg_dest;
  assign writeSP   = ctrl_q.write_sp;
  assign readSP    = ctrl_q.read_sp;
  assign updateSP  = ctrl_q.update_sp;
  assign writeReg  = ctrl_q.write_reg;
  assign aluSource = ctrl_q.alu_source;
  assign PM4       = ctrl_q.pm4;
  assign spmmux    = ctrl_q.spmmux;
  assign retMem    = ctrl_q.ret_mem;
  assign memRead   = ctrl_q.mem_read;
  assign memWrite  = ctrl_q.mem_write;
  assign memReg    = ctrl_q.mem_reg;
  assign spmux     = ctrl_q.spmux;
  assign moveReg   = ctrl_q.move_reg;
  assign jump      = ctrl_q.jump;
  assign retPC     = ctrl_q.ret_pc;
  assign haltPC    = ctrl_q.halt_pc;
  assign branch    = ctrl_q.branch;
  assign aluOp     = ctrl_q.alu_op;
  assign retire    = ctrl_q.retire;
  assign halted    = ctrl_q.halted;
  assign illegal   = illegal_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: two DUT configurations driven by shared stimulus, checked cycle by
// cycle against a per-instruction behavioural model of the control timeline.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pc_update, reg_dest, write_sp, read_sp, update_sp, write_reg, alu_source, pm4;
    logic       spmmux, ret_mem, mem_read, mem_write, mem_reg, spmux, move_reg, jump, ret_pc;
    logic       halt_pc, retire, halted, illegal;
    logic [1:0] branch;
    logic [3:0] alu_op;
  } tb_ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  wire tb_ctl_t obs_a, obs_b;
  wire [15:0]  icount_a;
  wire [1:0]   icount_b;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt_a = 0;
  int          exp_cnt_b = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(16), .STRICT_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .instr(instr),
    .PCUpdate(obs_a.pc_update), .regDest(obs_a.reg_dest), .writeSP(obs_a.write_sp),
    .readSP(obs_a.read_sp), .updateSP(obs_a.update_sp), .writeReg(obs_a.write_reg),
    .aluSource(obs_a.alu_source), .PM4(obs_a.pm4), .spmmux(obs_a.spmmux), .retMem(obs_a.ret_mem),
    .memRead(obs_a.mem_read), .memWrite(obs_a.mem_write), .memReg(obs_a.mem_reg),
    .spmux(obs_a.spmux), .moveReg(obs_a.move_reg), .jump(obs_a.jump), .retPC(obs_a.ret_pc),
    .haltPC(obs_a.halt_pc), .branch(obs_a.branch), .aluOp(obs_a.alu_op), .retire(obs_a.retire),
    .halted(obs_a.halted), .illegal(obs_a.illegal), .icount(icount_a)
  );

  multicycle_ctrl_fsm #(.CNT_W(2), .STRICT_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instr(instr),
    .PCUpdate(obs_b.pc_update), .regDest(obs_b.reg_dest), .writeSP(obs_b.write_sp),
    .readSP(obs_b.read_sp), .updateSP(obs_b.update_sp), .writeReg(obs_b.write_reg),
    .aluSource(obs_b.alu_source), .PM4(obs_b.pm4), .spmmux(obs_b.spmmux), .retMem(obs_b.ret_mem),
    .memRead(obs_b.mem_read), .memWrite(obs_b.mem_write), .memReg(obs_b.mem_reg),
    .spmux(obs_b.spmux), .moveReg(obs_b.move_reg), .jump(obs_b.jump), .retPC(obs_b.ret_pc),
    .haltPC(obs_b.halt_pc), .branch(obs_b.branch), .aluOp(obs_b.alu_op), .retire(obs_b.retire),
    .halted(obs_b.halted), .illegal(obs_b.illegal), .icount(icount_b)
  );

  function automatic bit is_legal(logic [5:0] op);
    return (op == 6'h00) || (op >= 6'h08 && op <= 6'h15) ||
           (op >= 6'h18 && op <= 6'h1C) || (op == 6'h3F);
  endfunction

  // Cycles from FETCH through WB; 0 means the instruction ends in HALT.
  function automatic int instr_len(logic [31:0] ins, bit strict);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h3F || (strict && !is_legal(op))) return 0;
    if (op inside {6'h10, 6'h11, [6'h19:6'h1C]}) return 5;
    return 4;
  endfunction

  // Expected controls during cycle cyc (0 = FETCH) of one instruction.
  function automatic tb_ctl_t model(logic [31:0] ins, int cyc, bit strict);
    tb_ctl_t    e;
    logic [5:0] op;
    int         len;
    bit         stack_op;
    e        = '0;
    op       = ins[31:26];
    len      = instr_len(ins, strict);
    stack_op = op inside {[6'h19:6'h1C]};
    if (cyc == 0) return e;
    if (len == 0) begin
      if (cyc >= 2) begin
        e.halt_pc   = 1'b1;
        e.pc_update = 1'b1;
        e.halted    = 1'b1;
        e.illegal   = !is_legal(op);
      end
      return e;
    end
    e.reg_dest   = (op == 6'h00);
    e.alu_source = op inside {[6'h08:6'h11]};
    e.spmux      = stack_op;
    e.alu_op     = (op == 6'h00) ? ins[3:0] : (op inside {[6'h08:6'h0F]}) ? {1'b0, op[2:0]} : 4'h0;
    e.branch     = (op == 6'h13) ? 2'b01 : (op == 6'h14) ? 2'b10 : (op == 6'h15) ? 2'b11 : 2'b00;
    if (cyc == 1) e.read_sp = stack_op;
    if (len == 5 && cyc == 3) begin
      e.mem_read  = op inside {6'h10, 6'h1A, 6'h1C};
      e.mem_write = op inside {6'h11, 6'h19, 6'h1B};
      e.ret_mem   = (op == 6'h1B);
      e.update_sp = (op == 6'h1B);
    end
    if (cyc == len - 1) begin
      e.pc_update = 1'b1;
      e.retire    = 1'b1;
      e.write_reg = op inside {6'h00, [6'h08:6'h10], 6'h18, 6'h1A};
      e.mem_reg   = op inside {6'h10, 6'h1A};
      e.move_reg  = (op == 6'h18);
      e.write_sp  = stack_op;
      e.pm4       = op inside {6'h19, 6'h1B};
      e.jump      = op inside {6'h12, 6'h1B};
      e.ret_pc    = (op == 6'h1C);
    end
    return e;
  endfunction

  function automatic logic [5:0] pick_legal();
    int idx;
    idx = $urandom_range(0, 19);
    if (idx == 0) return 6'h00;
    if (idx <= 8) return 6'(8 + idx - 1);
    if (idx <= 14) return 6'(16 + idx - 9);
    return 6'(24 + idx - 15);
  endfunction

  // Entered at a falling edge in FETCH; leaves at the falling edge of the following FETCH.
  // sel 0 observes the strict 16-bit DUT, sel 1 the lenient 2-bit-counter DUT.
  task automatic run_instr(input int sel, input logic [31:0] ins, input int halt_cycles,
                           input string name);
    bit      strict;
    int      len, ncyc, cnt_max, base, exp_n, got_n;
    tb_ctl_t exp_c, got;
    strict  = (sel == 0);
    len     = instr_len(ins, strict);
    ncyc    = (len == 0) ? halt_cycles : len;
    cnt_max = (sel == 0) ? 65535 : 3;
    base    = (sel == 0) ? exp_cnt_a : exp_cnt_b;
    instr   = ins;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        instr = $urandom();
      end
      exp_c = model(ins, c, strict);
      got   = (sel == 0) ? obs_a : obs_b;
      n_tests++;
      if (got !== exp_c) begin
        n_fail++;
        $display("FAIL %s ctl cyc%0d instr=%h got=%h want=%h", name, c, ins, got, exp_c);
      end
      exp_n = (len != 0 && c == len - 1 && base < cnt_max) ? base + 1 : base;
      got_n = (sel == 0) ? int'(icount_a) : int'(icount_b);
      n_tests++;
      if (got_n !== exp_n) begin
        n_fail++;
        $display("FAIL %s icount cyc%0d got=%0d want=%0d", name, c, got_n, exp_n);
      end
    end
    if (len != 0 && base < cnt_max) base++;
    if (sel == 0) exp_cnt_a = base;
    else          exp_cnt_b = base;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instr = $urandom();
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr = 32'h0022_1800;
    #1;
    n_tests++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%h/%h want=0", obs_a, obs_b);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_a !== '0 || icount_a !== 16'd0 || icount_b !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_held ctl=%h icount=%0d/%0d want 0", obs_a, icount_a, icount_b);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    run_instr(0, 32'h0022_1800, 0, "add");
    n_tests++;
    if (icount_a !== 16'd1) begin
      n_fail++;
      $display("FAIL add_icount got=%0d want=1", icount_a);
    end
  endtask

  task automatic test_ld();
    run_instr(0, 32'h4022_0004, 0, "ld");
  endtask

  task automatic test_call();
    run_instr(0, {6'h1B, 26'($urandom())}, 0, "call");
  endtask

  task automatic test_bz();
    run_instr(0, {6'h13, 26'($urandom())}, 0, "bz");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      run_instr(0, {pick_legal(), 26'($urandom())}, 0, "b2b");
  endtask

  task automatic test_reset_mid_mem();
    instr = {6'h11, 26'($urandom())};
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_a.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL st_mem_write got=%b want=1", obs_a.mem_write);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs_a !== '0 || icount_a !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mem ctl=%h icount=%0d want 0", obs_a, icount_a);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (obs_a !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_mem_leak ctl=%h want=0", obs_a);
    end
    @(negedge clk);
    reset     = 1'b1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    run_instr(0, 32'h0022_1800, 0, "add_after_reset");
  endtask

  task automatic test_halt();
    run_instr(0, 32'hFC00_0000, 22, "halt");
    do_reset();
  endtask

  task automatic test_illegal_strict();
    run_instr(0, {6'h3E, 26'($urandom())}, 10, "illegal_strict");
    do_reset();
  endtask

  task automatic test_illegal_nop();
    logic [5:0] op;
    do_reset();
    run_instr(1, {6'h3E, 26'($urandom())}, 0, "illegal_nop");
    for (int i = 0; i < 12; i++) begin
      op = 6'($urandom_range(0, 62));
      run_instr(1, {op, 26'($urandom())}, 0, "lenient_rand");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++)
      run_instr(1, {pick_legal(), 26'($urandom())}, 0, "saturate");
    n_tests++;
    if (icount_b !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate_final got=%0d want=3", icount_b);
    end
  endtask

  initial begin
    reset = 1'b0;
    instr = '0;
    test_reset();
    test_add();
    test_ld();
    test_call();
    test_bz();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    test_illegal_strict();
    test_illegal_nop();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
